// File: rtl/md_ctrl_if.sv
// Handshake/data bundle between the EX/ID stages and the multiply/divide sequencer.
// The pipeline side drives the master modport; md_ctrl uses the slave modport.
interface md_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wdata;
  logic        md_use_D;
  logic        busy;
  logic        md_stall_D;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B, hi_wr, lo_wr, wdata, md_use_D,
    input  busy, md_stall_D, HI, LO
  );

  modport slave (
    input  start, op, A, B, hi_wr, lo_wr, wdata, md_use_D,
    output busy, md_stall_D, HI, LO
  );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs fixed-latency mult/div, raises ID stall while busy.
// Result lands in HI/LO N edges after start; start and mthi/mtlo are ignored while busy.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_ctrl_if.slave   md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_load;
  logic               w_commit;
  logic [31:0]        r_res_hi;
  logic [31:0]        r_res_lo;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic [63:0]        w_prod;
  logic [31:0]        w_dvd;
  logic [31:0]        w_dvs;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic               w_neg_q;
  logic               w_neg_r;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;

  // Signed divide runs on magnitudes through the shared unsigned divider;
  // INT_MIN / -1 then falls out naturally as quotient 0x80000000, remainder 0.
  always_comb begin
    w_prod   = '0;
    w_dvd    = md.A;
    w_dvs    = md.B;
    w_neg_q  = 1'b0;
    w_neg_r  = 1'b0;
    w_uq     = '0;
    w_ur     = '0;
    w_res_hi = '0;
    w_res_lo = '0;
    if (md.op[0]) begin
      w_prod = {32'b0, md.A} * {32'b0, md.B};
    end else begin
      w_prod  = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
      w_dvd   = md.A[31] ? (32'd0 - md.A) : md.A;
      w_dvs   = md.B[31] ? (32'd0 - md.B) : md.B;
      w_neg_q = md.A[31] ^ md.B[31];
      w_neg_r = md.A[31];
    end
    if (md.B != 32'd0) begin
      w_uq = w_dvd / w_dvs;
      w_ur = w_dvd % w_dvs;
    end
    if (!md.op[1]) begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
    end else if (md.B == 32'd0) begin
      w_res_hi = md.A;
      w_res_lo = 32'hFFFF_FFFF;
    end else begin
      w_res_lo = w_neg_q ? (32'd0 - w_uq) : w_uq;
      w_res_hi = w_neg_r ? (32'd0 - w_ur) : w_ur;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (md.start) begin
          w_load      = 1'b1;
          w_cnt_nxt   = md.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_load) begin
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
      end
      if (w_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else if (r_state == IDLE && !md.start) begin
        if (md.hi_wr) r_hi <= md.wdata;
        if (md.lo_wr) r_lo <= md.wdata;
      end
    end
  end

  assign md.busy       = (r_state == RUN);
  assign md.md_stall_D = md.md_use_D & (md.start | md.busy);
  assign md.HI         = r_hi;
  assign md.LO         = r_lo;

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the five-stage pipeline. It owns the HI/LO register pair and runs mult, multu, div and divu issued from the EX stage as fixed-latency multi-cycle operations. It exports a busy flag and a decode-stage stall request so the hazard controller can hold an MD-class instruction in ID until the result is ready. mthi/mtlo writes go through it, and HI/LO feed the mfhi/mflo path.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (legal range ≥1)
- DIV_CYCLES, 10, busy duration for div/divu (legal range ≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- start  in  1  EX-stage MD arithmetic instruction valid this cycle
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
- A  in  32  forwarded rs value (EX)
- B  in  32  forwarded rt value (EX)
- hi_wr  in  1  mthi in EX
- lo_wr  in  1  mtlo in EX
- wdata  in  32  mthi/mtlo data (forwarded rs)
- md_use_D  in  1  ID-stage instruction is MD-class (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in progress
- md_stall_D  out  1  stall request to the hazard controller
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE and RUN. A down-counter cnt tracks the remaining cycles. Result latches res_hi and res_lo hold the pending result.
- IDLE, start=1:
  - Compute the result from A, B and op combinationally.
  - Latch it into res_hi/res_lo.
  - Load cnt with MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1).
  - Go to RUN.
- RUN: decrement cnt each cycle. When cnt reaches 1:
  - HI←res_hi, LO←res_lo at that edge.
  - Go to IDLE.
- busy = (state==RUN). This is registered, not combinational.
- md_stall_D = md_use_D & (start | busy). This is combinational.
- Arithmetic:
  - mult: signed 32×32→64, HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: signed. LO=quotient truncated toward zero; HI=remainder, which takes the sign of the dividend.
  - divu: unsigned. LO=quotient, HI=remainder.
- Divide by zero (B==0, div or divu): LO=32'hFFFFFFFF, HI=A.
- Signed overflow (div, A=32'h80000000, B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- mthi/mtlo:
  - In IDLE with start=0: hi_wr loads HI←wdata and lo_wr loads LO←wdata at the edge. Both may be asserted together.
  - While busy, or when start=1 in the same cycle, hi_wr/lo_wr are ignored. start wins.
- start while busy: ignored. The pending operation is unaffected.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, cnt=0, busy=0, HI=0, LO=0, res_hi=res_lo=0. md_stall_D follows its equation (0 unless md_use_D & start).
- start sampled at edge T:
  - busy=1 for cycles T+1 … T+N, where N is MULT_CYCLES or DIV_CYCLES.
  - HI/LO change at edge T+N.
  - busy=0 from edge T+N.
  - New HI/LO are readable by mfhi in EX on cycle T+N.
- HI/LO hold their old values throughout RUN.
- Reset asserted mid-RUN: operation aborted, the pending result is discarded, all registers return to reset values.
- A new start is accepted on the first cycle busy=0, giving back-to-back issue spacing of N+1 cycles.
- mthi/mtlo latency: 1 edge.

## Test plan
- mult A=32'hFFFFFFFE, B=3, defaults → busy high 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. Repeat with multu → HI=32'h00000002, LO=32'hFFFFFFFA.
- div A=32'hFFFFFFF9 (−7), B=2 → busy high 10 cycles; then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu A=100, B=7 → LO=14, HI=2.
- divu A=32'h12345678, B=0 → LO=32'hFFFFFFFF, HI=32'h12345678. div A=32'h80000000, B=32'hFFFFFFFF → LO=32'h80000000, HI=0.
- Hazard check:
  - md_use_D=1 held during mult → md_stall_D=1 on the start cycle and for all 5 busy cycles, then 0.
  - md_use_D=0 → md_stall_D=0 throughout.
  - A second start during RUN → ignored; the result equals the first operation.
- mthi wdata=32'hCAFEBABE while idle → HI=32'hCAFEBABE next edge. mtlo during busy → LO unchanged until the MD result lands. start and hi_wr in the same cycle → HI equals the MD result, not wdata.
- Reset: pull reset low on cycle 3 of a div → busy=0, HI=LO=0 immediately (asynchronous). After reset release, a fresh mult completes normally.
